uart_byte_receiver: RTL and testbench
=====================================

Name: uart_byte_receiver

Overview:
- Serial front end of the GPS chain. Deserialises the module's UART TX line (8N1, LSB first) into bytes.
- Presents each byte as a one-cycle `load` strobe plus `data`, ready to drive the GPZDA sentence receiver's `load`/`data` inputs directly.
- Flags framing faults so the sentence layer can discard the current sentence.

Parameters:
- ClockFreq, 100_000_000, system clock frequency in Hz.
- BaudRate, 9600, line rate in bit/s.
- B, 8, data bits per character.
- CyclesPerBit (localparam), ClockFreq/BaudRate (integer division); must be >= 4, otherwise elaboration fails.

Ports:
- clock  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line, idle high, asynchronous to clock.
- load  output  1  one-cycle strobe: `data` holds a valid received byte.
- data  output  B  last good byte; held until the next `load`.
- frame_error  output  1  one-cycle strobe: stop bit (or parity) was wrong; no `load` for that character.
- parity_error  output  1  one-cycle strobe on parity mismatch; constant 0 without the macro.
- busy  output  1  high while state is not S_Idle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = S_Idle, counters = 0.
  - load, frame_error, parity_error = 0; data = 0; busy = 0.
  - Synchroniser flops = 1.
- Synchroniser: `rx` passes through 2 flip-flops to give rx_s. All logic uses rx_s, so the pin-to-rx_s latency is 2 cycles.
- States: S_Idle, S_Start, S_Data, S_Parity (macro only), S_Stop, S_Break.
- t0 is the first cycle in S_Idle where rx_s = 0. Enter S_Start with the bit counter cleared.
- S_Start, sample at t0 + CyclesPerBit/2:
  - rx_s = 0: go to S_Data.
  - rx_s = 1: glitch; return to S_Idle silently, no strobes.
- S_Data:
  - Bit i (i = 0..B-1) is sampled at t0 + CyclesPerBit/2 + (i+1)*CyclesPerBit.
  - Shift in LSB first.
  - After bit B-1, go to S_Stop (or S_Parity when enabled).
- S_Stop, sample one bit period after the last data/parity sample:
  - rx_s = 1 and no parity fault: next cycle `load` = 1 and `data` = the shifted byte; go to S_Idle.
  - rx_s = 1 with a parity fault: next cycle `frame_error` = 1 and `parity_error` = 1; `data` unchanged, no `load`; go to S_Idle.
  - rx_s = 0: next cycle `frame_error` = 1; `data` unchanged; go to S_Break.
- S_Break: stay until rx_s = 1, then go to S_Idle. A held-low line never produces bytes.
- Latency, CyclesPerBit = 16, B = 8, no parity: start sample at t0+8, stop sample at t0+152, `load` high at cycle t0+153.
- Re-arming: S_Idle is entered at the middle of the stop bit, so a start edge immediately after the stop bit is caught. Back-to-back characters are received with no gap.
- Strobe exclusivity: `load` and `frame_error` are never high in the same cycle.
- Each strobe lasts exactly one cycle and is registered; no combinational path from rx.
- Reset mid-character: the partial byte is discarded, no strobe is issued, and `data` returns to 0.
- Sample counter: width $clog2(CyclesPerBit); it must not wrap during a bit.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - One even-parity bit follows data bit B-1, sampled one CyclesPerBit later in S_Parity.
  - The XOR of the data bits and the parity bit must be 0.
  - On mismatch, the stop-bit decision still runs, then `parity_error` and `frame_error` pulse together with no `load`.
  - Stop sample moves one bit period later: `load` at t0+169 for CyclesPerBit = 16.
- Undefined: no parity state; `parity_error` is tied to 0.

Test Plan (ClockFreq=1600, BaudRate=100, so CyclesPerBit=16):
- Send 0x24 ("$") 8N1 -> exactly one `load` pulse at t0+153, data=0x24, frame_error never high, busy low afterwards.
- Send "G","P" back-to-back, no idle gap -> two `load` pulses 160 cycles apart, data 0x47 then 0x50.
- 3-cycle low glitch on rx while idle -> no `load`/`frame_error`, busy returns low by t0+9.
- Send 0x5A with stop bit driven 0, then rx held low 400 cycles -> one `frame_error` pulse, no `load`, data keeps its prior value, busy stays high until rx rises.
- Assert reset_n low asynchronously during bit 4 of 0x41, release, then send 0x42 -> no strobe for 0x41, data=0 after reset, then `load` with data=0x42.
- UART_PARITY_EN: send 0x03 with parity 0 -> `load`, data=0x03; send 0x03 with parity 1 -> `parity_error` and `frame_error` pulse together, no `load`.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// UART byte receiver: 8N1 deserialiser (LSB first) with registered load / framing strobes.
// Define UART_PARITY_EN to expect one even-parity bit after the data bits.
module uart_byte_receiver #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 9600,
    parameter int B         = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         rx,
    output logic         load,
    output logic [B-1:0] data,
    output logic         frame_error,
    output logic         parity_error,
    output logic         busy
);
    localparam int CyclesPerBit = ClockFreq / BaudRate;
    localparam int CntW         = $clog2(CyclesPerBit);
    localparam int BitW         = $clog2(B + 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CyclesPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CyclesPerBit - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(B - 1);

    if (CyclesPerBit < 4) begin : g_bad_rate
        $error("uart_byte_receiver: ClockFreq/BaudRate must be at least 4");
    end

    typedef enum logic [2:0] {
        S_Idle,
        S_Start,
        S_Data,
`ifdef UART_PARITY_EN
        S_Parity,
`endif
        S_Stop,
        S_Break
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      rx_sync_q;
    logic            rx_s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [B-1:0]    shift_q, shift_d;
    logic [B-1:0]    data_q, data_d;
    logic            load_q, load_d;
    logic            ferr_q, ferr_d;
    logic            busy_q;
`ifdef UART_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_bad_q, par_bad_d;
`endif

    assign rx_s = rx_sync_q[1];

    // Next-state and strobe decode; every sample point is the last count of its bit slot.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        load_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_Idle: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = S_Start;
`ifdef UART_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    state_d = S_Idle;
                end
            end
            S_Start: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_Data;
                    end else begin
                        state_d = S_Idle;
                    end
                end else begin
                    state_d = S_Start;
                end
            end
            S_Data: begin
                if (cnt_q == FullLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[B-1:1]};
                    if (bit_q == LastBit) begin
                        bit_d = '0;
`ifdef UART_PARITY_EN
                        state_d = S_Parity;
`else
                        state_d = S_Stop;
`endif
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    state_d = S_Data;
                end
            end
`ifdef UART_PARITY_EN
            S_Parity: begin
                if (cnt_q == FullLast) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rx_s;
                    state_d   = S_Stop;
                end else begin
                    state_d = S_Parity;
                end
            end
`endif
            S_Stop: begin
                if (cnt_q == FullLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_Idle;
`ifdef UART_PARITY_EN
                        if (par_bad_q) begin
                            ferr_d = 1'b1;
                            perr_d = 1'b1;
                        end else begin
                            load_d = 1'b1;
                            data_d = shift_q;
                        end
`else
                        load_d = 1'b1;
                        data_d = shift_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_Break;
                    end
                end else begin
                    state_d = S_Stop;
                end
            end
            S_Break: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_Idle;
                end else begin
                    state_d = S_Break;
                end
            end
            default: begin
                state_d = S_Idle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath and output registers; synchroniser resets to the idle line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
            state_q   <= S_Idle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            load_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            load_q    <= load_d;
            ferr_q    <= ferr_d;
            busy_q    <= (state_d != S_Idle);
        end
    end

`ifdef UART_PARITY_EN
    // Parity verdict is held from the parity sample until the stop-bit decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    assign load        = load_q;
    assign data        = data_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: stimulus pushes expected strobes, a monitor pops them.
module tb_uart_byte_receiver;
    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        int         kind;   // 0 load, 1 frame error, 2 frame+parity error
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic       load;
    logic [7:0] data;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    int         cyc;
    int         n_checks;
    int         n_pass;
    logic [7:0] last_good;
    exp_t       sb[$];

    uart_byte_receiver #(.ClockFreq(1600), .BaudRate(100), .B(8)) dut (
        .clock(clk), .reset_n(reset_n), .rx(rx), .load(load), .data(data),
        .frame_error(frame_error), .parity_error(parity_error), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // Monitor: every strobe must match the oldest expected event in kind, data and cycle.
    always @(negedge clk) begin
        if (reset_n && (load || frame_error || parity_error)) begin
            int   k;
            exp_t e;
            chk("strobe_exclusive", {31'd0, load & frame_error}, 32'd0);
            k = load ? 0 : (frame_error && parity_error) ? 2 : frame_error ? 1 : 3;
            chk("strobe_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("strobe_kind", k, e.kind);
                chk("strobe_data", {24'd0, data}, {24'd0, e.data});
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic bit_period(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: character sent from an idle receiver strobes 2 sync cycles + half bit
    // + (start, data, parity) bit periods + 1 register cycle after the start edge.
    task automatic send_char(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        exp_t x;
        x.cyc = cyc + 2 + CPB / 2 + (8 + 1 + P) * CPB + 1;
        if (!stop_bit) begin
            x.kind = 1; x.data = last_good;
        end else if (P == 1 && par_flip) begin
            x.kind = 2; x.data = last_good;
        end else begin
            x.kind = 0; x.data = d; last_good = d;
        end
        sb.push_back(x);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
        if (P == 1) bit_period((^d) ^ par_flip);
        bit_period(stop_bit);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin
        int         e;
        logic [7:0] v;
        cyc       = 0;
        n_checks  = 0;
        n_pass    = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_load", {31'd0, load}, 32'd0);
        chk("reset_ferr", {31'd0, frame_error}, 32'd0);
        chk("reset_perr", {31'd0, parity_error}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        idle(10);

        send_char(8'h24, 1'b1, 1'b0);
        idle(20);
        drain("dollar_drain");
        chk("dollar_busy_after", {31'd0, busy}, 32'd0);

        send_char(8'h47, 1'b1, 1'b0);
        send_char(8'h50, 1'b1, 1'b0);
        idle(20);
        drain("gp_drain");

        e  = cyc;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (e + 10 - cyc) @(posedge clk);
        #1;
        chk("glitch_busy_at_t0p8", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("glitch_busy_at_t0p9", {31'd0, busy}, 32'd0);
        idle(40);
        drain("glitch_drain");

        send_char(8'h5A, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("break_busy_held", {31'd0, busy}, 32'd1);
        chk("break_data_kept", {24'd0, data}, 32'h50);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("break_busy_before_exit", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("break_busy_released", {31'd0, busy}, 32'd0);
        idle(20);
        drain("break_drain");

        v = 8'h41;
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(v[i]);
        rx = v[4];
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        last_good = 8'h00;
        idle(20);
        chk("midreset_data_after", {24'd0, data}, 32'd0);
        send_char(8'h42, 1'b1, 1'b0);
        idle(20);
        drain("midreset_drain");

`ifdef UART_PARITY_EN
        send_char(8'h03, 1'b1, 1'b0);
        idle(10);
        send_char(8'h03, 1'b1, 1'b1);
        idle(20);
        drain("parity_drain");
`endif

        for (int n = 0; n < 40; n++) begin
            logic bad_stop;
            logic flip;
            bad_stop = ($urandom_range(0, 7) == 0);
            flip     = ($urandom_range(0, 3) == 0);
            send_char(8'($urandom), !bad_stop, flip);
            if (bad_stop) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1;
                idle(16 + $urandom_range(0, 10));
            end else if ($urandom_range(0, 2) != 0) begin
                idle($urandom_range(1, 30));
            end
        end
        idle(20);
        drain("random_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
